keypad_scan: RTL and testbench
==============================

# keypad_scan

Scanning reader for the board's 4x4 active-low key matrix, the input-side counterpart of the row-scanned 8x8 dot-matrix driver. It drives one column low at a time and samples the four row lines. Each completed scan frame is reduced to a single-key code, debounced, and delivered through a valid/ready handshake. Traffic-light and display logic consume key codes from this block, for example as a pedestrian request or a mode select.

## Interface
- SCAN_DIV, 2500: clk cycles per column slot; legal range 3..65535.
- DEBOUNCE, 3: consecutive identical frames required to accept a press or a release; legal range 2..15.
- REPEAT_FRAMES, 32: frames between auto-repeat events; used only with KEYPAD_REPEAT_EN.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- key_row  in  4  row lines, active-low, pulled up externally; asynchronous to clk.
- key_col  out  4  column drive, active-low, exactly one bit low.
- key_code  out  4  accepted key, computed as row*4+col.
- key_valid  out  1  event pending.
- key_ready  in  1  consumer accepts the event.
- key_held  out  1  high while the FSM is in HELD.
- key_overflow  out  1  one-cycle pulse when an event is discarded.

## Operation
- key_row passes through a 2-flop synchronizer, reset value 4'b1111.
- Divider counts 0..SCAN_DIV-1 and emits a one-cycle tick at SCAN_DIV-1.
- col_idx 0..3 drives key_col = ~(1<<col_idx).
- On each tick:
  - The synchronized rows for the current col_idx are stored into a 16-bit frame.
  - col_idx then advances, wrapping 3 to 0.
  - The tick that samples col 3 completes the frame.
- Frame decode:
  - Exactly one bit low gives SINGLE(code).
  - All bits high gives NONE.
  - Two or more bits low gives MULTI, which is treated as NONE for acceptance (ghost rejection).
- FSM is evaluated once per completed frame:
  - IDLE:
    - SINGLE(c): cand=c, cnt=1, go to DEB.
    - Otherwise stay in IDLE.
  - DEB:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE, emit cand and go to HELD.
    - Anything else: go to IDLE.
  - HELD:
    - SINGLE(cand): stay.
    - Anything else: go to REL with cnt=1 if the frame is NONE, or cnt=0 if it is a different key or MULTI.
  - REL:
    - NONE: cnt+1. When cnt reaches DEBOUNCE, go to IDLE.
    - SINGLE(cand): return to HELD with no new event.
    - Other key or MULTI: cnt=0, stay in REL. A full release is required before a new key is accepted.
- Emit:
  - If key_valid=0: key_code=cand and key_valid=1 on the next clk.
  - If key_valid=1: the new event is dropped, key_code is unchanged, and key_overflow pulses for one cycle.
- Handshake:
  - key_valid && key_ready at a clk edge clears key_valid on that edge.
  - key_code holds its value after acceptance.
  - An emit in the same cycle as an acceptance is loaded as the new event; it is not an overflow.

## Timing
- Reset values (all asynchronous):
  - key_col=4'b1110, key_code=0, key_valid=0, key_held=0, key_overflow=0.
  - FSM=IDLE; divider, col_idx, cnt and frame all 0.
- One frame is 4*SCAN_DIV cycles.
- Rows are sampled SCAN_DIV cycles after the column change, so the synchronizer and external settling are covered.
- key_valid rises 1 cycle after the tick that completes the DEBOUNCE-th consecutive matching frame.
- Worst-case press-to-valid latency is (DEBOUNCE+1) frames + 3 cycles.
- key_held rises together with key_valid on the initial emit and falls on the HELD-to-REL transition.
- Reset asserted mid-operation clears key_valid immediately; a pending event is lost.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a frame counter increments on every SINGLE(cand) frame.
  - At REPEAT_FRAMES it re-emits cand under the normal emit/overflow rules and resets to 0.
  - The counter clears on entry to HELD.
- KEYPAD_REPEAT_EN undefined: exactly one event per press; no repeat counter is synthesized.

## Structure
- Shared package keypad_pkg holds:
  - the FSM state encoding (IDLE, DEB, HELD, REL);
  - KEY_W=4 and the column pattern constants;
  - the NONE/SINGLE/MULTI decode result type.
- Sub-module keypad_tick_gen contains the SCAN_DIV divider and produces the tick pulse.
- Synchronizer, frame capture, decode, FSM and output register stay in keypad_scan.

## Test plan
Common bench settings: SCAN_DIV=4, DEBOUNCE=3, frame = 16 cycles.
- Reset: hold reset=0 → key_col=1110, key_valid=0, key_overflow=0. Release reset → key_col cycles 1110, 1101, 1011, 0111 every 4 cycles.
- Clean press: model row1/col2 closed for 10 frames with key_ready=1 → exactly one key_valid pulse with key_code=6; key_held high until the first NONE frame.
- Bounce: toggle the row1/col2 contact every 10 cycles for 60 cycles, then hold closed → exactly one event, key_code=6.
- Multi-key: close code 0 and code 5 together → no event. Open code 5 → one event with key_code=0 three frames later.
- Handshake/overflow with key_ready=0:
  - Press and release code 9, then press code 3 → key_valid stays high with key_code=9 and key_overflow pulses once.
  - Raise key_ready → key_valid falls the same edge.
  - Assert reset while key_valid=1 → key_valid=0 immediately.
- Repeat: REPEAT_FRAMES=8, hold code 15 for 40 frames with key_ready=1.
  - With KEYPAD_REPEAT_EN: 5 events, at frames 3, 11, 19, 27 and 35.
  - Without KEYPAD_REPEAT_EN: 1 event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM encoding, column patterns
// and the frame decode helper.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  localparam logic [KEY_W-1:0] COL_ALL_OFF = 4'b1111;
  localparam logic [KEY_W-1:0] COL_FIRST   = 4'b1110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  typedef enum logic [1:0] {
    DecNone,
    DecSingle,
    DecMulti
  } dec_kind_e;

  typedef struct packed {
    dec_kind_e        kind;
    logic [KEY_W-1:0] code;
  } dec_t;

  function automatic logic [KEY_W-1:0] col_pattern(input logic [1:0] idx);
    logic [KEY_W-1:0] one_hot;
    one_hot = COL_FIRST ^ COL_ALL_OFF;
    return ~(one_hot << idx);
  endfunction

  // Frame bit row*4+col is low when that key is closed; code is only meaningful for DecSingle.
  function automatic dec_t decode_frame(input logic [15:0] frame);
    dec_t        d;
    int unsigned n_low;
    d.kind = DecNone;
    d.code = '0;
    n_low  = 0;
    for (int i = 0; i < 16; i++) begin
      if (!frame[i]) begin
        n_low++;
        d.code = KEY_W'(i);
      end
    end
    if (n_low == 1) begin
      d.kind = DecSingle;
    end else if (n_low > 1) begin
      d.kind = DecMulti;
    end
    return d;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Column-slot divider: counts 0..SCAN_DIV-1 and pulses o_tick for one cycle at the top.
module keypad_tick_gen
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 2500
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  logic [15:0] r_div;

  assign o_tick = (r_div == 16'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (o_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with frame debounce and valid/ready event output.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 2500,
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned REPEAT_FRAMES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_row,
  output logic [KEY_W-1:0] key_col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_held,
  output logic             key_overflow
);

  if (SCAN_DIV < 3 || SCAN_DIV > 65535 || DEBOUNCE < 2 || DEBOUNCE > 15 ||
      REPEAT_FRAMES < 1) begin : g_bad_param
    $error("keypad_scan: parameter out of legal range");
  end

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE);

  logic [KEY_W-1:0] r_row_meta, r_row_sync;
  logic             w_tick;
  logic [1:0]       r_col_idx;
  logic [15:0]      r_frame, w_frame_next;
  logic             w_frame_done;
  dec_t             w_dec;
  logic             w_match;
  logic [1:0]       r_state, w_state_d;
  logic [KEY_W-1:0] r_cand, w_cand_d;
  logic [3:0]       r_cnt, w_cnt_d, w_cnt_inc;
  logic             w_emit;
  logic [KEY_W-1:0] r_code;
  logic             r_valid, r_overflow;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_FRAMES + 1);
  localparam logic [REP_W-1:0] REP_N = REP_W'(REPEAT_FRAMES);
  logic [REP_W-1:0] r_rep, w_rep_d, w_rep_inc;
  assign w_rep_inc = r_rep + REP_W'(1);
`endif

  keypad_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .o_tick(w_tick)
  );

  always_comb begin
    w_frame_next = r_frame;
    for (int r = 0; r < 4; r++) begin
      w_frame_next[r*4 + int'(r_col_idx)] = r_row_sync[r];
    end
  end

  assign w_frame_done = w_tick && (r_col_idx == 2'd3);
  assign w_dec        = decode_frame(w_frame_next);
  assign w_match      = (w_dec.kind == DecSingle) && (w_dec.code == r_cand);
  assign w_cnt_inc    = r_cnt + 4'd1;

  always_comb begin
    w_state_d = r_state;
    w_cand_d  = r_cand;
    w_cnt_d   = r_cnt;
    w_emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_d   = r_rep;
`endif
    if (w_frame_done) begin
      case (r_state)
        ST_IDLE: begin
          if (w_dec.kind == DecSingle) begin
            w_cand_d  = w_dec.code;
            w_cnt_d   = 4'd1;
            w_state_d = ST_DEB;
          end
        end
        ST_DEB: begin
          if (!w_match) begin
            w_state_d = ST_IDLE;
          end else if (w_cnt_inc == DEB_N) begin
            w_emit    = 1'b1;
            w_state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
            w_rep_d   = '0;
`endif
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end
        ST_HELD: begin
          if (w_match) begin
`ifdef KEYPAD_REPEAT_EN
            if (w_rep_inc == REP_N) begin
              w_emit  = 1'b1;
              w_rep_d = '0;
            end else begin
              w_rep_d = w_rep_inc;
            end
`endif
          end else begin
            w_state_d = ST_REL;
            w_cnt_d   = (w_dec.kind == DecNone) ? 4'd1 : 4'd0;
          end
        end
        default: begin
          // ST_REL: any other key or ghost pattern restarts the release count.
          if (w_dec.kind == DecNone) begin
            if (w_cnt_inc == DEB_N) begin
              w_state_d = ST_IDLE;
            end else begin
              w_cnt_d = w_cnt_inc;
            end
          end else if (w_match) begin
            w_state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
            w_rep_d   = '0;
`endif
          end else begin
            w_cnt_d = 4'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_meta <= 4'b1111;
      r_row_sync <= 4'b1111;
      r_col_idx  <= '0;
      r_frame    <= '0;
      r_state    <= ST_IDLE;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_row_meta <= key_row;
      r_row_sync <= r_row_meta;
      if (w_tick) begin
        r_frame   <= w_frame_next;
        r_col_idx <= r_col_idx + 2'd1;
      end
      r_state    <= w_state_d;
      r_cand     <= w_cand_d;
      r_cnt      <= w_cnt_d;
      r_overflow <= w_emit && r_valid && !key_ready;
      if (w_emit && (!r_valid || key_ready)) begin
        r_code  <= r_cand;
        r_valid <= 1'b1;
      end else if (r_valid && key_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rep <= '0;
    end else begin
      r_rep <= w_rep_d;
    end
  end
`endif

  assign key_col      = col_pattern(r_col_idx);
  assign key_code     = r_code;
  assign key_valid    = r_valid;
  assign key_held     = (r_state == ST_HELD);
  assign key_overflow = r_overflow;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames), REPEAT_FRAMES=8.
module tb_keypad_scan;

  localparam int unsigned FRAME = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b1;
  logic        key_held;
  logic        key_overflow;
  logic [15:0] keys = '0;

  int n_vec = 0;
  int n_err = 0;
  int ev_cnt = 0;
  int ovf_cnt = 0;
  logic [3:0] last_code = '0;

  keypad_scan #(
    .SCAN_DIV     (4),
    .DEBOUNCE     (3),
    .REPEAT_FRAMES(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_row     (key_row),
    .key_col     (key_col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_held    (key_held),
    .key_overflow(key_overflow)
  );

  always #5 clk = ~clk;

  // Passive matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !key_col[c]) key_row[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (reset && key_valid && key_ready) begin
      ev_cnt    <= ev_cnt + 1;
      last_code <= key_code;
    end
    if (key_overflow) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [3:0] one;
    logic [3:0] exp_col;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (key_col !== 4'b1110 || key_valid !== 1'b0 || key_overflow !== 1'b0 ||
        key_held !== 1'b0 || key_code !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: col=%b valid=%b ovf=%b held=%b code=%0d, want 1110 0 0 0 0",
               key_col, key_valid, key_overflow, key_held, key_code);
    end
    reset = 1'b1;
    one   = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      exp_col = ~(one << ((k / 4) % 4));
      n_vec++;
      if (key_col !== exp_col) begin
        n_err++;
        $display("FAIL col_cycle[%0d]: got %b want %b", k, key_col, exp_col);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clean_press;
    int ev0;
    int cyc;
    ev0 = ev_cnt;
    keys = 16'h0040;
    cyc = 0;
    while (!key_valid && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (key_valid !== 1'b1 || cyc < 34 || cyc > 67) begin
      n_err++;
      $display("FAIL press_latency: valid=%b after %0d cycles, want 1 within 34..67", key_valid, cyc);
    end
    n_vec++;
    if (key_code !== 4'd6 || key_held !== 1'b1) begin
      n_err++;
      $display("FAIL press_code: code=%0d held=%b, want 6 1", key_code, key_held);
    end
    wait_frames(7);
    n_vec++;
    if (ev_cnt - ev0 !== 1 || last_code !== 4'd6 || key_held !== 1'b1) begin
      n_err++;
      $display("FAIL press_single_event: events=%0d code=%0d held=%b, want 1 6 1",
               ev_cnt - ev0, last_code, key_held);
    end
    keys = '0;
    wait_frames(2);
    n_vec++;
    if (key_held !== 1'b0) begin
      n_err++;
      $display("FAIL release_held: got %b want 0", key_held);
    end
    wait_frames(4);
    n_vec++;
    if (ev_cnt - ev0 !== 1) begin
      n_err++;
      $display("FAIL release_no_event: events=%0d want 1", ev_cnt - ev0);
    end
  endtask

  task automatic test_bounce;
    int ev0;
    ev0 = ev_cnt;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      repeat (10) @(negedge clk);
    end
    keys = 16'h0040;
    wait_frames(8);
    n_vec++;
    if (ev_cnt - ev0 !== 1 || last_code !== 4'd6) begin
      n_err++;
      $display("FAIL bounce: events=%0d code=%0d, want 1 6", ev_cnt - ev0, last_code);
    end
    keys = '0;
    wait_frames(6);
  endtask

  task automatic test_multi_key;
    int ev0;
    ev0 = ev_cnt;
    keys = 16'h0021;
    wait_frames(6);
    n_vec++;
    if (ev_cnt - ev0 !== 0 || key_held !== 1'b0) begin
      n_err++;
      $display("FAIL ghost_reject: events=%0d held=%b, want 0 0", ev_cnt - ev0, key_held);
    end
    keys = 16'h0001;
    wait_frames(2);
    n_vec++;
    if (ev_cnt - ev0 !== 0) begin
      n_err++;
      $display("FAIL multi_early: events=%0d want 0", ev_cnt - ev0);
    end
    wait_frames(3);
    n_vec++;
    if (ev_cnt - ev0 !== 1 || last_code !== 4'd0) begin
      n_err++;
      $display("FAIL multi_resolve: events=%0d code=%0d, want 1 0", ev_cnt - ev0, last_code);
    end
    keys = '0;
    wait_frames(6);
  endtask

  task automatic test_handshake_overflow;
    int ovf0;
    ovf0 = ovf_cnt;
    key_ready = 1'b0;
    keys = 16'h0200;
    wait_frames(5);
    keys = '0;
    wait_frames(5);
    keys = 16'h0008;
    wait_frames(5);
    n_vec++;
    if (key_valid !== 1'b1 || key_code !== 4'd9 || ovf_cnt - ovf0 !== 1) begin
      n_err++;
      $display("FAIL overflow: valid=%b code=%0d pulses=%0d, want 1 9 1",
               key_valid, key_code, ovf_cnt - ovf0);
    end
    key_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (key_valid !== 1'b0 || key_code !== 4'd9) begin
      n_err++;
      $display("FAIL ready_clears: valid=%b code=%0d, want 0 9", key_valid, key_code);
    end
    key_ready = 1'b0;
    keys = '0;
    wait_frames(5);
    keys = 16'h1000;
    wait_frames(5);
    n_vec++;
    if (key_valid !== 1'b1 || key_code !== 4'd12) begin
      n_err++;
      $display("FAIL second_event: valid=%b code=%0d, want 1 12", key_valid, key_code);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (key_valid !== 1'b0 || key_held !== 1'b0 || key_col !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_mid: valid=%b held=%b col=%b, want 0 0 1110", key_valid, key_held,
               key_col);
    end
    keys = '0;
    @(negedge clk);
    reset = 1'b1;
    key_ready = 1'b1;
    wait_frames(2);
  endtask

  task automatic test_repeat;
    int ev0;
    int exp_ev;
`ifdef KEYPAD_REPEAT_EN
    exp_ev = 5;
`else
    exp_ev = 1;
`endif
    ev0 = ev_cnt;
    keys = 16'h8000;
    wait_frames(40);
    keys = '0;
    wait_frames(6);
    n_vec++;
    if (ev_cnt - ev0 !== exp_ev || last_code !== 4'd15) begin
      n_err++;
      $display("FAIL repeat: events=%0d code=%0d, want %0d 15", ev_cnt - ev0, last_code, exp_ev);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_handshake_overflow();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
